// File: rtl/ctrl_pipe_pkg.sv
// ctrl_pipe_pkg: control word layout and default per-stage field masks for the E/M/W control pipeline
package ctrl_pipe_pkg;
  localparam int CTRL_W = 8;
  localparam int REGWRITE = 7;
  localparam int MEMTOREG = 6;
  localparam int MEMWRITE = 5;
  localparam int ALUSRC = 4;
  localparam int REGDST = 3;
  localparam int ALUOP_HI = 2;
  localparam int ALUOP_LO = 0;
  localparam logic [CTRL_W-1:0] KEEP_E = '1;
  localparam logic [CTRL_W-1:0] KEEP_M = CTRL_W'((1 << REGWRITE) | (1 << MEMTOREG) | (1 << MEMWRITE));
  localparam logic [CTRL_W-1:0] KEEP_W = CTRL_W'((1 << REGWRITE) | (1 << MEMTOREG));
  localparam logic [3*CTRL_W-1:0] KEEP_DEF = {KEEP_W, KEEP_M, KEEP_E};
endpackage

// File: rtl/ctrl_pipe_stage.sv
// ctrl_pipe_stage: one control register with hold/flush/bubble/load priority and load-time field masking
module ctrl_pipe_stage import ctrl_pipe_pkg::*; #(
  parameter int W = CTRL_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         hold,
  input  logic         flush,
  input  logic         up_hold,
  input  logic [W-1:0] src_word,
  input  logic         src_valid,
  input  logic [W-1:0] keep,
  output logic [W-1:0] word,
  output logic         valid,
  output logic         flush_ev,
  output logic         bubble_ev
);
  logic load;
  assign load = ~hold & ~flush & ~up_hold & src_valid;
  assign flush_ev = ~hold & flush & ~up_hold & src_valid;
  assign bubble_ev = ~hold & ~flush & up_hold;
  // hold keeps the entry; otherwise an invalid or killed source leaves a zero word
  always_ff @(posedge clk) begin
    if (reset) begin
      word <= '0;
      valid <= 1'b0;
    end else if (!hold) begin
      word <= load ? src_word & keep : '0;
      valid <= load;
    end
  end
endmodule

// File: rtl/ctrl_pipe_chain.sv
// ctrl_pipe_chain: NSTAGE-deep control word pipeline with stall back-propagation, flush and event counters
module ctrl_pipe_chain import ctrl_pipe_pkg::*; #(
  parameter int NSTAGE = 3,
  parameter int W = CTRL_W,
  parameter logic [NSTAGE*W-1:0] KEEP = '1,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [W-1:0]        in_word,
  input  logic                in_valid,
  input  logic [NSTAGE-1:0]   stall,
  input  logic [NSTAGE-1:0]   flush,
  output logic                in_ready,
  output logic [NSTAGE*W-1:0] stage_word,
  output logic [NSTAGE-1:0]   stage_valid,
  output logic [CNT_W-1:0]    bubble_cnt,
  output logic [CNT_W-1:0]    flush_cnt
);
  logic [NSTAGE-1:0] hold, fl_ev, bb_ev;
  logic [CNT_W:0] f_sum;
  assign in_ready = ~hold[0];
  for (genvar g = 0; g < NSTAGE; g++) begin : st
    logic [W-1:0] sw;
    logic sv, uh;
    assign hold[g] = |stall[NSTAGE-1:g];
    if (g == 0) begin : s0
      assign sw = in_word;
      assign sv = in_valid;
      assign uh = 1'b0;
    end else begin : sn
      assign sw = stage_word[(g-1)*W +: W];
      assign sv = stage_valid[g-1];
      assign uh = hold[g-1];
    end
    ctrl_pipe_stage #(.W(W)) u_stage (
      .clk(clk), .reset(reset), .hold(hold[g]), .flush(flush[g]), .up_hold(uh),
      .src_word(sw), .src_valid(sv), .keep(KEEP[g*W +: W]),
      .word(stage_word[g*W +: W]), .valid(stage_valid[g]),
      .flush_ev(fl_ev[g]), .bubble_ev(bb_ev[g])
    );
  end
  // sum all flush kills of this cycle onto the counter with one extra bit to detect overflow
  always_comb begin
    f_sum = {1'b0, flush_cnt};
    for (int k = 0; k < NSTAGE; k++) f_sum = f_sum + (CNT_W+1)'(fl_ev[k]);
  end
  // saturating event counters; only one bubble is possible per cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      bubble_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      bubble_cnt <= bubble_cnt + CNT_W'(|bb_ev && !(&bubble_cnt));
      flush_cnt <= f_sum[CNT_W] ? '1 : f_sum[CNT_W-1:0];
    end
  end
endmodule

// File: tb/tb_ctrl_pipe_chain.sv
// tb_ctrl_pipe_chain: table-driven directed check of the control pipeline, with a 2-bit-counter twin
module tb_ctrl_pipe_chain;
  import ctrl_pipe_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] in_word = '0;
  logic in_valid = 1'b0;
  logic [2:0] stall = '0, flush = '0;
  logic in_ready, in_ready2;
  logic [23:0] stage_word, stage_word2;
  logic [2:0] stage_valid, stage_valid2;
  logic [15:0] bubble_cnt, flush_cnt;
  logic [1:0] bubble_cnt2, flush_cnt2;
  int n_run = 0, n_fail = 0;

  typedef struct {
    logic [2:0] st, fl;
    logic [7:0] w;
    logic v, rdy;
    logic [23:0] ew;
    logic [2:0] ev;
    int eb, ef;
  } vec_t;
  vec_t tv[20];

  always #5 clk = ~clk;

  ctrl_pipe_chain #(.NSTAGE(3), .W(8), .KEEP(KEEP_DEF), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_word(in_word), .in_valid(in_valid), .stall(stall), .flush(flush),
    .in_ready(in_ready), .stage_word(stage_word), .stage_valid(stage_valid),
    .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt));

  ctrl_pipe_chain #(.NSTAGE(3), .W(8), .KEEP(KEEP_DEF), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .in_word(in_word), .in_valid(in_valid), .stall(stall), .flush(flush),
    .in_ready(in_ready2), .stage_word(stage_word2), .stage_valid(stage_valid2),
    .bubble_cnt(bubble_cnt2), .flush_cnt(flush_cnt2));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int sat3(input int x);
    return x > 3 ? 3 : x;
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, " words"}, 32'(stage_word), 32'h0);
    chk({tag, " valid"}, 32'(stage_valid), 32'h0);
    chk({tag, " bubble_cnt"}, 32'(bubble_cnt), 32'h0);
    chk({tag, " flush_cnt"}, 32'(flush_cnt), 32'h0);
    chk({tag, " bubble_cnt2"}, 32'(bubble_cnt2), 32'h0);
    chk({tag, " flush_cnt2"}, 32'(flush_cnt2), 32'h0);
  endtask

  initial begin
    //         stall   flush   word   v  rdy  {s2,s1,s0}   valid   bub fl
    tv[0]  = '{3'b000, 3'b000, 8'hFF, 1, 1, 24'h0000FF, 3'b001, 0, 0};
    tv[1]  = '{3'b000, 3'b000, 8'hFF, 1, 1, 24'h00E0FF, 3'b011, 0, 0};
    tv[2]  = '{3'b000, 3'b000, 8'hFF, 1, 1, 24'hC0E0FF, 3'b111, 0, 0};
    tv[3]  = '{3'b000, 3'b000, 8'hA5, 1, 1, 24'hC0E0A5, 3'b111, 0, 0};
    tv[4]  = '{3'b010, 3'b000, 8'h5A, 1, 0, 24'h00E0A5, 3'b011, 1, 0};
    tv[5]  = '{3'b010, 3'b000, 8'h5A, 1, 0, 24'h00E0A5, 3'b011, 2, 0};
    tv[6]  = '{3'b000, 3'b000, 8'h5A, 1, 1, 24'hC0A05A, 3'b111, 2, 0};
    tv[7]  = '{3'b000, 3'b000, 8'h3C, 1, 1, 24'h80403C, 3'b111, 2, 0};
    tv[8]  = '{3'b001, 3'b001, 8'h00, 0, 0, 24'h40003C, 3'b101, 3, 0};
    tv[9]  = '{3'b000, 3'b000, 8'h11, 1, 1, 24'h002011, 3'b011, 3, 0};
    tv[10] = '{3'b000, 3'b000, 8'h22, 1, 1, 24'h000022, 3'b111, 3, 0};
    tv[11] = '{3'b000, 3'b111, 8'h33, 1, 1, 24'h000000, 3'b000, 3, 3};
    tv[12] = '{3'b000, 3'b000, 8'h44, 1, 1, 24'h000044, 3'b001, 3, 3};
    tv[13] = '{3'b000, 3'b000, 8'h88, 1, 1, 24'h004088, 3'b011, 3, 3};
    tv[14] = '{3'b001, 3'b100, 8'h99, 1, 0, 24'h000088, 3'b001, 4, 4};
    tv[15] = '{3'b000, 3'b000, 8'h99, 1, 1, 24'h008099, 3'b011, 4, 4};
    tv[16] = '{3'b000, 3'b010, 8'hAA, 1, 1, 24'h8000AA, 3'b101, 4, 5};
    tv[17] = '{3'b100, 3'b000, 8'hBB, 1, 0, 24'h8000AA, 3'b101, 4, 5};
    tv[18] = '{3'b100, 3'b111, 8'hBB, 1, 0, 24'h8000AA, 3'b101, 4, 5};
    tv[19] = '{3'b010, 3'b000, 8'hBB, 1, 0, 24'h0000AA, 3'b001, 5, 5};

    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    chk("reset in_ready", 32'(in_ready), 32'h1);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      stall = tv[i].st;
      flush = tv[i].fl;
      in_word = tv[i].w;
      in_valid = tv[i].v;
      #1;
      chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(tv[i].rdy));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d words", i), 32'(stage_word), 32'(tv[i].ew));
      chk($sformatf("v%0d valid", i), 32'(stage_valid), 32'(tv[i].ev));
      chk($sformatf("v%0d bubble_cnt", i), 32'(bubble_cnt), 32'(tv[i].eb));
      chk($sformatf("v%0d flush_cnt", i), 32'(flush_cnt), 32'(tv[i].ef));
      chk($sformatf("v%0d bubble_cnt2", i), 32'(bubble_cnt2), 32'(sat3(tv[i].eb)));
      chk($sformatf("v%0d flush_cnt2", i), 32'(flush_cnt2), 32'(sat3(tv[i].ef)));
    end

    // reset while the stall is still asserted and entries are in flight
    @(negedge clk);
    stall = 3'b010;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk_zero("midreset");
    @(negedge clk);
    stall = 3'b000;
    #1;
    chk("midreset in_ready", 32'(in_ready), 32'h1);
    @(posedge clk);
    #1;
    chk_zero("midreset hold");
    @(negedge clk);
    reset = 1'b0;
    in_word = 8'h7E;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("post-reset load", 32'(stage_word), 32'h00007E);
    chk("post-reset valid", 32'(stage_valid), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
